// File: rtl/byte_store_unit.sv
// Byte-serial little-endian store engine: narrows a 32-bit value to byte/half/word,
// writes it through an 8-bit ready/valid memory port and flags lossless narrowing.
module byte_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           store_data_in,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [1:0]            size_in,
  input  logic                  mem_ready,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [7:0]            mem_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  lossless
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic [DATA_W-1:0]     r_data, w_data;
  logic [ADDR_WIDTH-1:0] r_base, w_base;
  logic [1:0]            r_size, w_size;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [IDX_W-1:0]      r_last, w_last;

  logic                  r_mem_write_en, w_mem_write_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [BYTE_W-1:0]     r_mem_data, w_mem_data;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_error, w_error;
  logic                  r_lossless, w_lossless;

  logic                  w_illegal;

  // Little-endian byte lane select.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [DATA_W-1:0] data,
                                                 input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

  // Sign-extending the stored field reproduces the full register value.
  function automatic logic narrow_ok(input logic [DATA_W-1:0] data, input logic [1:0] size);
    logic ok;
    case (size)
      SZ_BYTE: ok = (data[31:8]  == {24{data[7]}});
      SZ_HALF: ok = (data[31:16] == {16{data[15]}});
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign w_illegal = (size_in == 2'b11)
                   | ((size_in == SZ_HALF) & address_in[0])
                   | ((size_in == SZ_WORD) & (address_in[1:0] != 2'b00));

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    w_state        = r_state;
    w_data         = r_data;
    w_base         = r_base;
    w_size         = r_size;
    w_idx          = r_idx;
    w_last         = r_last;
    w_mem_write_en = 1'b0;
    w_mem_addr     = '0;
    w_mem_data     = '0;
    w_done         = 1'b0;
    w_error        = 1'b0;
    w_lossless     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_data = store_data_in;
          w_base = address_in;
          w_size = size_in;
          w_idx  = '0;
          if (w_illegal) begin
            w_state = S_ERROR;
            w_error = 1'b1;
          end else begin
            w_state        = S_SEND;
            w_last         = (size_in == SZ_BYTE) ? 2'd0 :
                             (size_in == SZ_HALF) ? 2'd1 : 2'd3;
            w_mem_write_en = 1'b1;
            w_mem_addr     = address_in;
            w_mem_data     = store_data_in[7:0];
          end
        end
      end
      S_SEND: begin
        if (mem_ready && (r_idx == r_last)) begin
          w_state    = S_DONE;
          w_done     = 1'b1;
          w_lossless = narrow_ok(r_data, r_size);
        end else begin
          // Stalled cycles re-present the same index; accepted ones advance it.
          if (mem_ready) begin
            w_idx = r_idx + 2'd1;
          end
          w_mem_write_en = 1'b1;
          w_mem_addr     = r_base + ADDR_WIDTH'(w_idx);
          w_mem_data     = byte_sel(r_data, w_idx);
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_ERROR: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_data         <= '0;
      r_base         <= '0;
      r_size         <= '0;
      r_idx          <= '0;
      r_last         <= '0;
      r_mem_write_en <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_lossless     <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_data         <= w_data;
      r_base         <= w_base;
      r_size         <= w_size;
      r_idx          <= w_idx;
      r_last         <= w_last;
      r_mem_write_en <= w_mem_write_en;
      r_mem_addr     <= w_mem_addr;
      r_mem_data     <= w_mem_data;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_error        <= w_error;
      r_lossless     <= w_lossless;
    end
  end

  assign mem_write_en = r_mem_write_en;
  assign mem_addr_out = r_mem_addr;
  assign mem_data_out = r_mem_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign lossless     = r_lossless;

endmodule

// File: tb/tb_byte_store_unit.sv
// Self-checking bench for byte_store_unit: directed vector table, reset-abort
// sequence and randomized requests checked against a behavioural store model.
module tb_byte_store_unit;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   store_data_in;
  logic [AW-1:0] address_in;
  logic [1:0]    size_in;
  logic          mem_ready;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr_out;
  logic [7:0]    mem_data_out;
  logic          busy;
  logic          done;
  logic          error;
  logic          lossless;

  int checks = 0;
  int errors = 0;

  byte_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .store_data_in(store_data_in),
    .address_in   (address_in),
    .size_in      (size_in),
    .mem_ready    (mem_ready),
    .mem_write_en (mem_write_en),
    .mem_addr_out (mem_addr_out),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .lossless     (lossless)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [63:0] stall;
    logic        hold;
    logic        exp_err;
    logic        exp_loss;
    int          exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: legality, lossless by signed-value comparison, done cycle by walking stalls.
  function automatic logic model_legal(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic model_loss(input logic [31:0] d, input logic [1:0] sz);
    byte     b;
    shortint h;
    int      v;
    b = d[7:0];
    h = d[15:0];
    if (sz == 2'd0) v = b;
    else if (sz == 2'd1) v = h;
    else v = int'(d);
    return v == int'(d);
  endfunction

  function automatic int model_done(input logic [1:0] sz, input logic [63:0] stall);
    int n = 1 << sz;
    int k = 0;
    int c = 1;
    while (k < n && c < 60) begin
      if (!stall[c]) k++;
      c++;
    end
    return c;
  endfunction

  task automatic run_req(input string name, input logic [31:0] d, input logic [31:0] a,
                         input logic [1:0] sz, input logic [63:0] stall, input logic hold,
                         input logic exp_err, input logic exp_loss, input int exp_done);
    int          k = 0;
    int          we_cyc = 0;
    int          done_cyc = 0;
    int          err_cyc = 0;
    int          viol = 0;
    int          end_c;
    logic        got_loss = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    end_c = exp_err ? 1 : exp_done;
    @(negedge clk);
    start = 1'b1; store_data_in = d; address_in = a; size_in = sz; mem_ready = 1'b1;
    for (int c = 1; c <= end_c + 1; c++) begin
      @(negedge clk);
      start = hold && (c <= end_c);
      if (hold) begin
        store_data_in = ~d;
        address_in    = a + 32'h40;
      end
      mem_ready = !stall[c];
      if (mem_write_en) begin
        we_cyc++;
        if (prev_stall && (mem_addr_out !== prev_addr || mem_data_out !== prev_data)) viol++;
        if (mem_ready) begin
          chk($sformatf("%s wr%0d", name, k), {24'd0, mem_addr_out, mem_data_out},
              {24'd0, 32'(a + 32'(k)), 8'(d >> (8 * k))});
          k++;
        end
        prev_stall = !mem_ready;
        prev_addr  = mem_addr_out;
        prev_data  = mem_data_out;
      end else begin
        if (mem_addr_out != 0 || mem_data_out != 0) viol++;
        prev_stall = 1'b0;
      end
      if (done && done_cyc == 0) begin
        done_cyc = c;
        got_loss = lossless;
      end
      if (error && err_cyc == 0) err_cyc = c;
      if (done && error) viol++;
      if (lossless && !done) viol++;
      if (busy !== (c <= end_c)) viol++;
    end
    start = 1'b0;
    mem_ready = 1'b1;
    chk({name, " nwrites"},  64'(k),        exp_err ? 64'd0 : 64'(1 << sz));
    chk({name, " we_cyc"},   64'(we_cyc),   exp_err ? 64'd0 : 64'(exp_done - 1));
    chk({name, " done_cyc"}, 64'(done_cyc), exp_err ? 64'd0 : 64'(exp_done));
    chk({name, " err_cyc"},  64'(err_cyc),  exp_err ? 64'd1 : 64'd0);
    chk({name, " lossless"}, 64'(got_loss), exp_err ? 64'd0 : 64'(exp_loss));
    chk({name, " protocol"}, 64'(viol),     64'd0);
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"word",       32'h12345678, 32'h100,      2'd2, 64'h0,  1'b0, 1'b0, 1'b1, 5};
    vecs[1]  = '{"byte_ok",    32'hFFFFFF80, 32'h7,        2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 2};
    vecs[2]  = '{"byte_lossy", 32'h00000180, 32'h7,        2'd0, 64'h0,  1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{"half_bp",    32'h0000ABCD, 32'h22,       2'd1, 64'h6,  1'b0, 1'b0, 1'b0, 5};
    vecs[4]  = '{"word_mis",   32'h12345678, 32'h102,      2'd2, 64'h0,  1'b0, 1'b1, 1'b0, 0};
    vecs[5]  = '{"half_mis",   32'h00001234, 32'h101,      2'd1, 64'h0,  1'b0, 1'b1, 1'b0, 0};
    vecs[6]  = '{"size11",     32'h00000012, 32'h0,        2'd3, 64'h0,  1'b0, 1'b1, 1'b0, 0};
    vecs[7]  = '{"busy_start", 32'hCAFEF00D, 32'h40,       2'd2, 64'h0,  1'b1, 1'b0, 1'b1, 5};
    vecs[8]  = '{"half_neg",   32'hFFFF8000, 32'h10,       2'd1, 64'h0,  1'b0, 1'b0, 1'b1, 3};
    vecs[9]  = '{"half_stall", 32'h00007FFF, 32'h12,       2'd1, 64'h4,  1'b0, 1'b0, 1'b1, 4};
    vecs[10] = '{"word_stall", 32'h00000001, 32'h0,        2'd2, 64'h2A, 1'b0, 1'b0, 1'b1, 8};
    vecs[11] = '{"word_top",   32'h89ABCDEF, 32'hFFFFFFFC, 2'd2, 64'h0,  1'b1, 1'b0, 1'b1, 5};

    rst_n = 1'b0; start = 1'b0; store_data_in = '0; address_in = '0; size_in = '0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {23'd0, mem_write_en, mem_addr_out, mem_data_out, busy, done, error, lossless},
        64'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_req(vecs[i].name, vecs[i].d, vecs[i].a, vecs[i].sz, vecs[i].stall, vecs[i].hold,
              vecs[i].exp_err, vecs[i].exp_loss, vecs[i].exp_done);

    // Reset while the second byte of a word store is on the bus.
    @(negedge clk);
    start = 1'b1; store_data_in = 32'h11223344; address_in = 32'h200; size_in = 2'd2;
    mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_first_write", {23'd0, mem_write_en, mem_addr_out, mem_data_out},
        {23'd0, 1'b1, 32'h200, 8'h44});
    @(negedge clk);
    chk("rst_second_write", {23'd0, mem_write_en, mem_addr_out, mem_data_out},
        {23'd0, 1'b1, 32'h201, 8'h33});
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_abort", {23'd0, mem_write_en, mem_addr_out, mem_data_out, busy, done, error, lossless},
        64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", {23'd0, mem_write_en, mem_addr_out, mem_data_out, busy, done, error, lossless},
        64'd0);
    run_req("post_rst_byte", 32'h0000007F, 32'h5, 2'd0, 64'h0, 1'b0, 1'b0, 1'b1, 2);

    for (int r = 0; r < 40; r++) begin
      logic [31:0] d;
      logic [31:0] a;
      logic [1:0]  sz;
      logic [63:0] stall;
      logic        hold;
      logic        legal;
      byte         rb;
      shortint     rh;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case ($urandom_range(0, 2))
        0: d = $urandom;
        1: begin rb = byte'($urandom); d = 32'(int'(rb)); end
        default: begin rh = shortint'($urandom); d = 32'(int'(rh)); end
      endcase
      stall = {$urandom, $urandom} & {$urandom, $urandom};
      stall[0] = 1'b0;
      hold  = 1'($urandom_range(0, 1));
      legal = model_legal(a, sz);
      run_req($sformatf("rnd%0d", r), d, a, sz, stall, hold, !legal,
              legal ? model_loss(d, sz) : 1'b0, legal ? model_done(sz, stall) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
